// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, 1-cycle imem requester and DEPTH-entry prefetch FIFO feeding decode.
// Optional perf counters (stall_cnt_o, flush_cnt_o) built only when FETCH_PERF_EN is defined.
module fetch_queue #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int          PC_STEP  = 4,
  parameter int          CC_W     = 16,
  localparam int         PW       = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0] out_pc_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [PW:0]       level_o,
  output logic [CC_W-1:0]   cc_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q;
  logic              inflight_q;
  logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CC_W-1:0]   cc_q;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [PW+1:0]     occ;
  logic              issue, push, pop, empty, full;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign occ = {1'b0, level_o} + (PW+2)'(inflight_q);
  // Credit counts words already in flight; a same-cycle pop does not free one.
  assign issue = rst_ni && !redirect_i && (occ < (PW+2)'(DEPTH));
  assign push = inflight_q && !redirect_i;
  assign pop = !empty && out_ready_i && !redirect_i;
  assign imem_req_o = issue;
  assign imem_addr_o = fetch_pc_q;
  assign out_valid_o = !empty;
  assign out_instr_o = empty ? '0 : instr_mem[rd_ptr_q[PW-1:0]];
  assign out_pc_o = empty ? '0 : pc_mem[rd_ptr_q[PW-1:0]];
  assign cc_o = cc_q;
  always_comb begin
    fetch_pc_d = redirect_i ? (redirect_pc_i & ~ADDR_W'(3)) :
                 issue ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    wr_ptr_d = redirect_i ? rd_ptr_q : wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cc_q          <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= fetch_pc_q;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cc_q          <= cc_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q[PW-1:0]] <= imem_rdata_i;
      pc_mem[wr_ptr_q[PW-1:0]]    <= inflight_pc_q;
    end
  end
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
`ifdef FETCH_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic [16:0] flush_sum;
  assign flush_sum = {1'b0, flush_q} + 17'(occ);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!empty && !out_ready_i && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
      if (redirect_i) flush_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue (32-bit default and 8-bit wrapping instance).
module tb_fetch_queue;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, ready = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0, rdata = '0, rdata8 = '0;
  logic        req, valid, req8, valid8;
  logic [31:0] addr, instr, pc, instr8;
  logic [7:0]  addr8, pc8;
  logic [2:0]  level, level8;
  logic [15:0] cc, stall, flush, cc8, stall8, flush8;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fetch_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .out_valid_o(valid), .out_ready_i(ready), .out_instr_o(instr), .out_pc_o(pc),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .level_o(level), .cc_o(cc),
    .stall_cnt_o(stall), .flush_cnt_o(flush)
  );
  fetch_queue #(.ADDR_W(8), .RESET_PC(248)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .imem_req_o(req8), .imem_addr_o(addr8), .imem_rdata_i(rdata8),
    .out_valid_o(valid8), .out_ready_i(1'b1), .out_instr_o(instr8), .out_pc_o(pc8),
    .redirect_i(1'b0), .redirect_pc_i(8'h00), .level_o(level8), .cc_o(cc8),
    .stall_cnt_o(stall8), .flush_cnt_o(flush8)
  );
  always_ff @(posedge clk) begin
    rdata  <= addr >> 2;
    rdata8 <= 32'(addr8 >> 2);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_seq(input logic rdy);
    rst_n = 1'b0;
    redirect = 1'b0;
    ready = rdy;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_cc", 32'(cc), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    // streaming with decode always ready
    reset_seq(1'b1);
    chk("t1_req0", 32'(req), 1);
    chk("t1_addr0", addr, 0);
    chk("t5_addr0", 32'(addr8), 32'hF8);
    step();
    chk("t1_addr1", addr, 4);
    chk("t1_valid1", 32'(valid), 0);
    step();
    chk("t1_valid2", 32'(valid), 1);
    chk("t1_pc2", pc, 0);
    chk("t1_instr2", instr, 0);
    chk("t5_pc2", 32'(pc8), 32'hF8);
    step();
    chk("t1_pc3", pc, 4);
    chk("t1_instr3", instr, 1);
    chk("t1_level3", 32'(level), 1);
    chk("t5_pc3", 32'(pc8), 32'hFC);
    step();
    chk("t1_pc4", pc, 8);
    chk("t5_pc4", 32'(pc8), 32'h00);
    step();
    chk("t1_pc5", pc, 32'hC);
    chk("t5_pc5", 32'(pc8), 32'h04);
    chk("t1_cc5", 32'(cc), 5);
    // decode stalled from reset: fill then drain
    reset_seq(1'b0);
    step(); step(); step(); step();
    chk("t2_level4", 32'(level), 3);
    chk("t2_req4", 32'(req), 0);
    step();
    chk("t2_level5", 32'(level), 4);
    chk("t2_req5", 32'(req), 0);
    chk("t2_addr5", addr, 32'h10);
    chk("t2_pc5", pc, 0);
    chk("t2_stall5", 32'(stall), PERF ? 3 : 0);
    ready = 1'b1;
    step();
    chk("t2_pc6", pc, 4);
    chk("t2_level6", 32'(level), 3);
    step();
    chk("t2_pc7", pc, 8);
    step();
    chk("t2_pc8", pc, 32'hC);
    step();
    chk("t2_pc9", pc, 32'h10);
    chk("t2_valid9", 32'(valid), 1);
    // redirect while three words buffered plus one in flight
    reset_seq(1'b0);
    step(); step(); step(); step();
    chk("t3_level4", 32'(level), 3);
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("t3_req_redir", 32'(req), 0);
    step();
    redirect = 1'b0;
    #1;
    chk("t3_level5", 32'(level), 0);
    chk("t3_valid5", 32'(valid), 0);
    chk("t3_addr5", addr, 32'h40);
    chk("t3_req5", 32'(req), 1);
    chk("t3_flush5", 32'(flush), PERF ? 4 : 0);
    step();
    chk("t3_valid6", 32'(valid), 0);
    step();
    chk("t3_pc7", pc, 32'h40);
    chk("t3_instr7", instr, 32'h10);
    step();
    chk("t3_pc8", pc, 32'h44);
    // back-to-back redirects, last one with misaligned target
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    #1;
    chk("t4_addr", addr, 32'h100);
    chk("t4_level", 32'(level), 0);
    step(); step();
    chk("t4_valid", 32'(valid), 1);
    chk("t4_pc", pc, 32'h100);
    // asynchronous reset mid-stream with a response pending
    reset_seq(1'b0);
    step(); step(); step();
    chk("t6_level3", 32'(level), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(valid), 0);
    chk("t6_level", 32'(level), 0);
    chk("t6_pc", pc, 0);
    chk("t6_instr", instr, 0);
    chk("t6_req", 32'(req), 0);
    chk("t6_cc", 32'(cc), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_addr0", addr, 0);
    step(); step();
    chk("t6_level2", 32'(level), 1);
    chk("t6_pc2", pc, 0);
    chk("t6_cc2", 32'(cc), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
